proj_read_sched: RTL and testbench

Per-event read scheduler feeding the VM projection router from up to NSRC projection memories. On each event start it latches per-source projection counts and the event BX. It then issues one read per cycle, round-robin across non-empty sources, and drives the memory read address plus a source select for the router's input mux. It emits a data-aligned valid/source tag and signals completion, so the router sees a gap-free projection stream.

---
 rtl/tracklet_pkg.sv | 16 +
 rtl/rr_pick.sv | 27 ++
 rtl/proj_read_sched.sv | 145 ++++++++++++++
 tb/tb_proj_read_sched.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/tracklet_pkg.sv
// Shared widths and FSM encoding for the tracklet projection path.
package tracklet_pkg;

  localparam int unsigned BX_W        = 3;
  localparam int unsigned IDX_W       = 6;
  localparam int unsigned PROJ_ADDR_W = BX_W + IDX_W;
  localparam int unsigned PROJ_W      = 54;
  localparam int unsigned VMPROJ_W    = 13;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StScan  = 2'd1,
    StFlush = 2'd2
  } sched_state_e;

endpackage

// File: rtl/rr_pick.sv
// Combinational rotating-priority arbiter: grants the first requester after ptr_i (cyclic).
module rr_pick #(
  parameter int unsigned NumReq = 4,
  parameter int unsigned IdxW   = 2
) (
  input  logic [NumReq-1:0] req_i,
  input  logic [IdxW-1:0]   ptr_i,
  output logic [IdxW-1:0]   gnt_o,
  output logic              any_o
);

  logic [IdxW-1:0] cand;

  // Walk offsets from farthest to nearest so the nearest requester wins.
  always_comb begin
    gnt_o = '0;
    cand  = '0;
    any_o = |req_i;
    for (int off = int'(NumReq); off >= 1; off--) begin
      cand = IdxW'((int'(ptr_i) + off) % int'(NumReq));
      if (req_i[cand]) begin
        gnt_o = cand;
      end
    end
  end

endmodule

// File: rtl/proj_read_sched.sv
// Per-event round-robin read scheduler for the projection memories feeding the VM router.
module proj_read_sched
  import tracklet_pkg::*;
#(
  parameter int unsigned NumSrc = 4,
  parameter int unsigned CntW   = 7,
  parameter int unsigned RdLat  = 2,
  parameter int unsigned SrcW   = 2
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic                     start_i,
  input  logic [BX_W-1:0]          bx_i,
  input  logic [NumSrc*CntW-1:0]   nproj_i,
  output logic                     rd_en_o,
  output logic [PROJ_ADDR_W-1:0]   read_projection_o,
  output logic [SrcW-1:0]          src_sel_o,
  output logic                     proj_valid_o,
  output logic [SrcW-1:0]          proj_src_o,
  output logic                     busy_o,
  output logic                     done_o,
  output logic                     overrun_o
);

  localparam int unsigned MaxCnt = 64;

  sched_state_e           state_q;
  logic [CntW-1:0]        rem_q [NumSrc];
  logic [IDX_W-1:0]       idx_q [NumSrc];
  logic [SrcW-1:0]        ptr_q;
  logic [BX_W-1:0]        bx_q;
  logic [2:0]             flush_cnt_q;
  logic                   rd_en_q, busy_q, done_q, overrun_q;
  logic [SrcW-1:0]        src_sel_q;
  logic [PROJ_ADDR_W-1:0] rd_addr_q;
  logic [SrcW:0]          pipe_q [RdLat];

  logic [CntW-1:0]        cnt_clamped [NumSrc];
  logic [NumSrc-1:0]      req;
  logic [SrcW-1:0]        gnt;
  logic                   any_req;

  always_comb begin
    for (int i = 0; i < int'(NumSrc); i++) begin
      cnt_clamped[i] = (nproj_i[i*CntW +: CntW] > CntW'(MaxCnt)) ? CntW'(MaxCnt)
                                                                : nproj_i[i*CntW +: CntW];
      req[i]         = (rem_q[i] != '0);
    end
  end

  rr_pick #(
    .NumReq (NumSrc),
    .IdxW   (SrcW)
  ) u_rr_pick (
    .req_i (req),
    .ptr_i (ptr_q),
    .gnt_o (gnt),
    .any_o (any_req)
  );

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q     <= StIdle;
      ptr_q       <= '0;
      bx_q        <= '0;
      flush_cnt_q <= '0;
      rd_en_q     <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      overrun_q   <= 1'b0;
      src_sel_q   <= '0;
      rd_addr_q   <= '0;
      for (int i = 0; i < int'(NumSrc); i++) begin
        rem_q[i] <= '0;
        idx_q[i] <= '0;
      end
    end else begin
      done_q    <= 1'b0;
      overrun_q <= 1'b0;
      rd_en_q   <= 1'b0;
      // A start always (re)loads; outside IDLE it aborts the running event.
      if (start_i) begin
        overrun_q <= (state_q != StIdle);
        state_q   <= StScan;
        busy_q    <= 1'b1;
        bx_q      <= bx_i;
        ptr_q     <= SrcW'(NumSrc - 1);
        for (int i = 0; i < int'(NumSrc); i++) begin
          rem_q[i] <= cnt_clamped[i];
          idx_q[i] <= '0;
        end
      end else begin
        unique case (state_q)
          StIdle: busy_q <= 1'b0;
          StScan: begin
            if (any_req) begin
              rd_en_q    <= 1'b1;
              src_sel_q  <= gnt;
              rd_addr_q  <= {bx_q, idx_q[gnt]};
              rem_q[gnt] <= rem_q[gnt] - CntW'(1);
              idx_q[gnt] <= idx_q[gnt] + IDX_W'(1);
              ptr_q      <= gnt;
            end else begin
              state_q     <= StFlush;
              flush_cnt_q <= 3'(RdLat - 1);
            end
          end
          StFlush: begin
            if (flush_cnt_q == '0) begin
              done_q  <= 1'b1;
              state_q <= StIdle;
            end else begin
              flush_cnt_q <= flush_cnt_q - 3'd1;
            end
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

  // Aligns the read strobe and source tag with data returning from the memories.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      for (int i = 0; i < int'(RdLat); i++) begin
        pipe_q[i] <= '0;
      end
    end else begin
      pipe_q[0] <= {rd_en_q, src_sel_q};
      for (int i = 1; i < int'(RdLat); i++) begin
        pipe_q[i] <= pipe_q[i-1];
      end
    end
  end

  assign rd_en_o           = rd_en_q;
  assign read_projection_o = rd_addr_q;
  assign src_sel_o         = src_sel_q;
  assign proj_valid_o      = pipe_q[RdLat-1][SrcW];
  assign proj_src_o        = pipe_q[RdLat-1][SrcW-1:0];
  assign busy_o            = busy_q;
  assign done_o            = done_q;
  assign overrun_o         = overrun_q;

endmodule

// File: tb/tb_proj_read_sched.sv
// Directed and randomized checks of proj_read_sched against a per-cycle timeline model.
module tb_proj_read_sched;

  localparam int NSRC = 4;
  localparam int CNTW = 7;
  localparam int L    = 2;
  localparam int MAXC = 1024;

  logic             clk = 1'b0;
  logic             reset;
  logic             start;
  logic [2:0]       bx;
  logic [27:0]      nproj;
  logic             rd_en, proj_valid, busy, done, overrun;
  logic [8:0]       read_projection;
  logic [1:0]       src_sel, proj_src;

  int errors = 0;
  int checks = 0;

  bit          e_rd   [MAXC];
  int          e_src  [MAXC];
  int          e_addr [MAXC];
  bit          e_done [MAXC];
  bit          e_busy [MAXC];
  bit          e_ovr  [MAXC];
  bit          s_go   [MAXC];
  logic [2:0]  s_bx   [MAXC];
  logic [27:0] s_np   [MAXC];

  always #5 clk = ~clk;

  proj_read_sched dut (
    .clk_i             (clk),
    .reset_i           (reset),
    .start_i           (start),
    .bx_i              (bx),
    .nproj_i           (nproj),
    .rd_en_o           (rd_en),
    .read_projection_o (read_projection),
    .src_sel_o         (src_sel),
    .proj_valid_o      (proj_valid),
    .proj_src_o        (proj_src),
    .busy_o            (busy),
    .done_o            (done),
    .overrun_o         (overrun)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [27:0] pack(input int a, input int b, input int c, input int d);
    return {7'(d), 7'(c), 7'(b), 7'(a)};
  endfunction

  task automatic clear_plan();
    for (int c = 0; c < MAXC; c++) begin
      e_rd[c] = 0; e_src[c] = 0; e_addr[c] = 0; e_done[c] = 0;
      e_busy[c] = 0; e_ovr[c] = 0; s_go[c] = 0; s_bx[c] = '0; s_np[c] = '0;
    end
  endtask

  // Schedule a start in cycle s; anything planned after s for an older event is aborted.
  task automatic plan(input int s, input logic [27:0] np, input int b, output int n);
    int rem [NSRC];
    int id  [NSRC];
    int p, pick;
    e_ovr[s+1] = e_busy[s] && !e_done[s];
    for (int c = s + 1; c < MAXC; c++) begin
      e_rd[c] = 0; e_done[c] = 0; e_busy[c] = 0;
    end
    n = 0;
    for (int i = 0; i < NSRC; i++) begin
      rem[i] = int'(np[i*CNTW +: CNTW]);
      if (rem[i] > 64) rem[i] = 64;
      id[i] = 0;
      n += rem[i];
    end
    p = NSRC - 1;
    for (int k = 0; k < n; k++) begin
      pick = -1;
      for (int off = 1; off <= NSRC && pick < 0; off++) begin
        if (rem[(p + off) % NSRC] > 0) pick = (p + off) % NSRC;
      end
      e_rd[s+2+k]   = 1;
      e_src[s+2+k]  = pick;
      e_addr[s+2+k] = b * 64 + id[pick];
      rem[pick]--;
      id[pick]++;
      p = pick;
    end
    for (int c = s + 1; c <= s + n + 2 + L; c++) e_busy[c] = 1;
    e_done[s+n+2+L] = 1;
    s_go[s] = 1;
    s_bx[s] = 3'(b);
    s_np[s] = np;
  endtask

  task automatic run(input int len);
    for (int c = 0; c < len; c++) begin
      int  n;
      bit  pv;
      start = s_go[c];
      bx    = s_bx[c];
      nproj = s_np[c];
      @(posedge clk);
      #1;
      start = 1'b0;
      n  = c + 1;
      pv = (n >= L) ? e_rd[n-L] : 1'b0;
      chk($sformatf("rd_en@%0d", n), 32'(rd_en), 32'(e_rd[n]));
      if (e_rd[n]) begin
        chk($sformatf("src_sel@%0d", n), 32'(src_sel), 32'(e_src[n]));
        chk($sformatf("read_projection@%0d", n), 32'(read_projection), 32'(e_addr[n]));
      end
      chk($sformatf("proj_valid@%0d", n), 32'(proj_valid), 32'(pv));
      if (pv) chk($sformatf("proj_src@%0d", n), 32'(proj_src), 32'(e_src[n-L]));
      chk($sformatf("done@%0d", n), 32'(done), 32'(e_done[n]));
      chk($sformatf("busy@%0d", n), 32'(busy), 32'(e_busy[n]));
      chk($sformatf("overrun@%0d", n), 32'(overrun), 32'(e_ovr[n]));
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_rd_en"}, 32'(rd_en), 0);
    chk({tag, "_read_projection"}, 32'(read_projection), 0);
    chk({tag, "_src_sel"}, 32'(src_sel), 0);
    chk({tag, "_proj_valid"}, 32'(proj_valid), 0);
    chk({tag, "_proj_src"}, 32'(proj_src), 0);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_done"}, 32'(done), 0);
    chk({tag, "_overrun"}, 32'(overrun), 0);
  endtask

  initial begin
    int n1, n2, g, last;
    reset = 1'b1;
    start = 1'b0;
    bx    = '0;
    nproj = '0;
    #12;
    chk_all_zero("reset");
    @(posedge clk);
    #1 reset = 1'b0;

    // Mixed counts, documented grant order and addresses.
    clear_plan();
    plan(0, pack(3, 0, 2, 1), 5, n1);
    run(n1 + L + 5);

    // Empty event.
    clear_plan();
    plan(0, pack(0, 0, 0, 0), 3, n1);
    run(n1 + L + 5);

    // Clamp 100 -> 64 reads on source 1.
    clear_plan();
    plan(0, pack(0, 100, 0, 0), 7, n1);
    run(n1 + L + 5);

    // Restart during SCAN: overrun, abort, in-flight data still delivered.
    clear_plan();
    plan(0, pack(5, 5, 5, 5), 2, n1);
    plan(3, pack(5, 5, 5, 5), 6, n2);
    run(3 + n2 + L + 5);

    // Start in the final FLUSH cycle: overrun and no done for the first event.
    clear_plan();
    plan(0, pack(1, 0, 0, 0), 1, n1);
    plan(n1 + 1 + L, pack(0, 2, 0, 0), 4, n2);
    run(n1 + 1 + L + n2 + L + 5);

    // Back-to-back: start in the cycle after done.
    clear_plan();
    plan(0, pack(1, 1, 0, 0), 3, n1);
    plan(n1 + 3 + L, pack(1, 1, 0, 0), 4, n2);
    run(n1 + 3 + L + n2 + L + 5);

    // Asynchronous reset mid-SCAN, then a fresh event straight away.
    clear_plan();
    plan(0, pack(5, 5, 5, 5), 1, n1);
    run(5);
    #2 reset = 1'b1;
    #1;
    chk_all_zero("midreset");
    @(posedge clk);
    #1;
    chk_all_zero("heldreset");
    reset = 1'b0;
    clear_plan();
    plan(0, pack(2, 1, 0, 3), 5, n1);
    run(n1 + L + 5);

    // Randomized events, optionally with a second start at a random offset.
    for (int r = 0; r < 6; r++) begin
      clear_plan();
      plan(0, pack($urandom_range(0, 70), $urandom_range(0, 70), $urandom_range(0, 70),
                   $urandom_range(0, 70)), $urandom_range(0, 7), n1);
      last = n1;
      g    = 0;
      if ($urandom_range(0, 1) == 1) begin
        g = $urandom_range(1, n1 + 6);
        plan(g, pack($urandom_range(0, 20), $urandom_range(0, 20), $urandom_range(0, 20),
                     $urandom_range(0, 20)), $urandom_range(0, 7), n2);
        last = n2;
      end
      run(g + last + L + 5);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
